// File: rtl/seg_pattern_pkg.sv
// Shared constants and types for the seven-segment sequence checker:
// the index-to-pattern table, the ambiguous pattern and the tracking states.
package seg_pattern_pkg;

  // Entry i is the segment pattern shown for sequence index i.
  // Entries 4 and 7 share a pattern, so that pattern alone cannot name an index.
  localparam logic [7:0][6:0] PATTERN_TABLE = {
    7'b0100000,  // 7
    7'b0000100,  // 6
    7'b0001000,  // 5
    7'b0100000,  // 4
    7'b0010000,  // 3
    7'b0000001,  // 2
    7'b1000000,  // 1
    7'b0000010   // 0
  };

  localparam logic [6:0] AMBIGUOUS_PATTERN = 7'b0100000;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    SYNC   = 2'd1,
    LOCKED = 2'd2
  } state_t;

endpackage

// File: rtl/seg_pattern_lookup.sv
// Combinational decode of a 7-bit segment pattern into a sequence index.
// is_unique flags a pattern that names exactly one index; is_ambiguous flags
// the pattern shared by indices 4 and 7. Anything else decodes as invalid.
module seg_pattern_lookup
  import seg_pattern_pkg::*;
(
  input  logic [6:0] segment,
  output logic [2:0] index,
  output logic       is_unique,
  output logic       is_ambiguous
);

  logic [7:0] hits;

  // One-hot compare against every table entry, excluding the shared pattern.
  always_comb begin
    hits         = 8'b0000_0000;
    index        = 3'd0;
    is_unique    = 1'b0;
    is_ambiguous = (segment == AMBIGUOUS_PATTERN);
    for (int i = 0; i < 8; i++) begin
      hits[i] = (segment == PATTERN_TABLE[i]) && (segment != AMBIGUOUS_PATTERN);
    end
    case (hits)
      8'b0000_0001: begin index = 3'd0; is_unique = 1'b1; end
      8'b0000_0010: begin index = 3'd1; is_unique = 1'b1; end
      8'b0000_0100: begin index = 3'd2; is_unique = 1'b1; end
      8'b0000_1000: begin index = 3'd3; is_unique = 1'b1; end
      8'b0010_0000: begin index = 3'd5; is_unique = 1'b1; end
      8'b0100_0000: begin index = 3'd6; is_unique = 1'b1; end
      default:      begin index = 3'd0; is_unique = 1'b0; end
    endcase
  end

endmodule

// File: rtl/seg_pattern_checker.sv
// Seven-segment sequence checker: hunts for a decodable pattern, confirms
// LOCK_MATCHES in-order samples, then flywheels through mismatches while
// locked until LOSS_MISSES consecutive misses drop it back to HUNT.
// Optional mismatch counter on o_err_count: define SEG_CHECK_ERRCNT_EN.
module seg_pattern_checker
  import seg_pattern_pkg::*;
#(
  parameter int LOCK_MATCHES = 4,
  parameter int LOSS_MISSES  = 2
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_valid,
  input  logic [6:0] i_segment,
  output logic [2:0] o_index,
  output logic       o_index_valid,
  output logic       o_locked,
  output logic       o_error,
  output logic [7:0] o_err_count
);

  localparam int MW = $clog2(LOCK_MATCHES + 1);
  localparam int LW = $clog2(LOSS_MISSES + 1);

  state_t          state, state_nx;
  logic [2:0]      expected, expected_nx;
  logic [MW-1:0]   match_cnt, match_nx;
  logic [LW-1:0]   miss_cnt, miss_nx;
  logic [2:0]      index_nx;
  logic            index_valid_nx;
  logic            error_nx;

  logic [2:0]      dec_index;
  logic            dec_unique;
  logic            dec_ambiguous;
  logic            is_match;

  seg_pattern_lookup u_lookup (
    .segment      (i_segment),
    .index        (dec_index),
    .is_unique    (dec_unique),
    .is_ambiguous (dec_ambiguous)
  );

  // The shared pattern counts as in-order only where it could stand for the expected index.
  always_comb begin
    is_match = (dec_unique && (dec_index == expected)) ||
               (dec_ambiguous && ((expected == 3'd4) || (expected == 3'd7)));
  end

  // Next-state and next-output decision for one qualified sample.
  always_comb begin
    state_nx       = state;
    expected_nx    = expected;
    match_nx       = match_cnt;
    miss_nx        = miss_cnt;
    index_nx       = o_index;
    index_valid_nx = 1'b0;
    error_nx       = 1'b0;
    if (i_valid) begin
      case (state)
        HUNT: begin
          if (dec_unique) begin
            state_nx       = SYNC;
            expected_nx    = dec_index + 3'd1;
            match_nx       = MW'(1);
            index_nx       = dec_index;
            index_valid_nx = 1'b1;
          end else begin
            state_nx = HUNT;
          end
        end
        SYNC: begin
          if (is_match) begin
            expected_nx    = expected + 3'd1;
            index_nx       = expected;
            index_valid_nx = 1'b1;
            if (match_cnt == MW'(LOCK_MATCHES - 1)) begin
              state_nx = LOCKED;
              match_nx = '0;
              miss_nx  = '0;
            end else begin
              match_nx = match_cnt + MW'(1);
            end
          end else if (dec_unique) begin
            // Re-acquire on the new pattern rather than falling all the way back.
            expected_nx    = dec_index + 3'd1;
            match_nx       = MW'(1);
            index_nx       = dec_index;
            index_valid_nx = 1'b1;
          end else begin
            state_nx = HUNT;
            match_nx = '0;
          end
        end
        LOCKED: begin
          // Expected advances on every sample so a miss does not cost alignment.
          expected_nx = expected + 3'd1;
          if (is_match) begin
            index_nx       = expected;
            index_valid_nx = 1'b1;
            miss_nx        = '0;
          end else begin
            error_nx = 1'b1;
            if (miss_cnt == LW'(LOSS_MISSES - 1)) begin
              state_nx = HUNT;
              miss_nx  = '0;
            end else begin
              miss_nx = miss_cnt + LW'(1);
            end
          end
        end
        default: begin
          state_nx = HUNT;
          match_nx = '0;
          miss_nx  = '0;
        end
      endcase
    end else begin
      state_nx = state;
    end
  end

  // Tracking state and registered outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state         <= HUNT;
      expected      <= 3'd0;
      match_cnt     <= '0;
      miss_cnt      <= '0;
      o_index       <= 3'd0;
      o_index_valid <= 1'b0;
      o_locked      <= 1'b0;
      o_error       <= 1'b0;
    end else begin
      state         <= state_nx;
      expected      <= expected_nx;
      match_cnt     <= match_nx;
      miss_cnt      <= miss_nx;
      o_index       <= index_nx;
      o_index_valid <= index_valid_nx;
      o_locked      <= (state_nx == LOCKED);
      o_error       <= error_nx;
    end
  end

`ifdef SEG_CHECK_ERRCNT_EN
  // Saturating tally of locked-state mismatches; kept across loss of lock.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_err_count <= 8'd0;
    end else if (error_nx && (o_err_count != 8'hFF)) begin
      o_err_count <= o_err_count + 8'd1;
    end else begin
      o_err_count <= o_err_count;
    end
  end
`else
  assign o_err_count = 8'd0;
`endif

endmodule

// File: tb/tb_seg_pattern_checker.sv
// Randomised and directed bench for seg_pattern_checker with a sample-level
// reference model built from the pattern table and the tracking rules.
module tb_seg_pattern_checker;

  localparam int LOCK = 4;
  localparam int LOSS = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       valid = 1'b0;
  logic [6:0] segment = 7'd0;
  logic [2:0] o_index;
  logic       o_index_valid, o_locked, o_error;
  logic [7:0] o_err_count;

  int n_vec = 0;
  int n_bad = 0;

  logic [6:0] tbl [8] = '{7'b0000010, 7'b1000000, 7'b0000001, 7'b0010000,
                          7'b0100000, 7'b0001000, 7'b0000100, 7'b0100000};

  // Model state: mode 0 = hunting, 1 = confirming, 2 = locked.
  int         m_mode, m_exp, m_matches, m_misses;
  logic [2:0] m_index;
  logic       m_iv, m_locked, m_err;
  logic [7:0] m_cnt;

  seg_pattern_checker #(.LOCK_MATCHES(LOCK), .LOSS_MISSES(LOSS)) dut (
    .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_segment(segment),
    .o_index(o_index), .o_index_valid(o_index_valid), .o_locked(o_locked),
    .o_error(o_error), .o_err_count(o_err_count)
  );

  always #5 clk = ~clk;

  function automatic int table_hits(input logic [6:0] s, output int first);
    int n = 0;
    first = -1;
    for (int i = 0; i < 8; i++) begin
      if (tbl[i] == s) begin
        if (n == 0) first = i;
        n++;
      end
    end
    return n;
  endfunction

  task automatic model_step(input bit r, input bit v, input logic [6:0] s);
    int first, n;
    bit uniq, amb, matched;
    m_iv = 1'b0;
    m_err = 1'b0;
    if (r) begin
      m_mode = 0; m_exp = 0; m_matches = 0; m_misses = 0;
      m_index = 3'd0; m_locked = 1'b0; m_cnt = 8'd0;
      return;
    end
    if (!v) return;
    n = table_hits(s, first);
    uniq = (n == 1);
    amb = (n == 2);
    matched = (uniq && first == m_exp) || (amb && (m_exp == 4 || m_exp == 7));
    if (m_mode == 0 || (m_mode == 1 && !matched)) begin
      if (uniq) begin
        m_mode = 1; m_exp = (first + 1) % 8; m_matches = 1;
        m_index = 3'(first); m_iv = 1'b1;
      end else begin
        m_mode = 0;
      end
    end else if (m_mode == 1) begin
      m_index = 3'(m_exp); m_iv = 1'b1;
      m_exp = (m_exp + 1) % 8;
      m_matches++;
      if (m_matches >= LOCK) begin
        m_mode = 2; m_misses = 0;
      end
    end else begin
      if (matched) begin
        m_index = 3'(m_exp); m_iv = 1'b1; m_misses = 0;
      end else begin
        m_err = 1'b1;
`ifdef SEG_CHECK_ERRCNT_EN
        if (m_cnt != 8'd255) m_cnt = m_cnt + 8'd1;
`endif
        m_misses++;
        if (m_misses >= LOSS) begin
          m_mode = 0; m_misses = 0;
        end
      end
      m_exp = (m_exp + 1) % 8;
    end
    m_locked = (m_mode == 2);
  endtask

  // Apply one sample between edges, advance the model, then settle past the edge.
  task automatic drive(input bit r, input bit v, input logic [6:0] s);
    @(negedge clk);
    rst = r; valid = v; segment = s;
    @(posedge clk);
    model_step(r, v, s);
    #1;
  endtask

  task automatic test_reset();
    drive(1'b1, 1'b1, tbl[0]);
    drive(1'b1, 1'b0, 7'd0);
    n_vec++;
    if ({o_index, o_index_valid, o_locked, o_error, o_err_count} !== 14'd0) begin
      n_bad++;
      $display("FAIL reset_state got %h want 0", {o_index, o_index_valid, o_locked, o_error, o_err_count});
    end
  endtask

  task automatic test_lock_sequence();
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 1'b1, tbl[i]);
      n_vec++;
      if ({o_index, o_index_valid, o_locked, o_error, o_err_count} !== {m_index, m_iv, m_locked, m_err, m_cnt}) begin
        n_bad++;
        $display("FAIL lock_seq[%0d] got %h want %h", i, {o_index, o_index_valid, o_locked, o_error, o_err_count}, {m_index, m_iv, m_locked, m_err, m_cnt});
      end
      n_vec++;
      if (o_index_valid !== 1'b1 || o_index !== 3'(i) || o_locked !== (i >= 3)) begin
        n_bad++;
        $display("FAIL lock_seq_idx[%0d] got idx=%0d v=%b lk=%b want idx=%0d v=1 lk=%b", i, o_index, o_index_valid, o_locked, i, (i >= 3));
      end
    end
  endtask

  task automatic test_wrap();
    for (int k = 0; k < 10; k++) begin
      drive(1'b0, 1'b1, tbl[k % 8]);
      n_vec++;
      if (o_index !== 3'(k % 8) || o_index_valid !== 1'b1 || o_error !== 1'b0 || o_locked !== 1'b1) begin
        n_bad++;
        $display("FAIL wrap[%0d] got idx=%0d v=%b err=%b lk=%b want idx=%0d v=1 err=0 lk=1", k, o_index, o_index_valid, o_error, o_locked, k % 8);
      end
    end
  endtask

  task automatic test_single_error();
    int pulses = 0;
    logic [6:0] seq [9];
    seq = '{tbl[6], tbl[7], tbl[0], tbl[1], tbl[2], 7'b0000000, tbl[4], tbl[5], tbl[6]};
    drive(1'b1, 1'b0, 7'd0);
    for (int k = 0; k < 9; k++) begin
      drive(1'b0, 1'b1, seq[k]);
      if (o_error === 1'b1) pulses++;
      n_vec++;
      if ({o_index, o_index_valid, o_locked, o_error, o_err_count} !== {m_index, m_iv, m_locked, m_err, m_cnt}) begin
        n_bad++;
        $display("FAIL single_err[%0d] got %h want %h", k, {o_index, o_index_valid, o_locked, o_error, o_err_count}, {m_index, m_iv, m_locked, m_err, m_cnt});
      end
    end
    n_vec++;
`ifdef SEG_CHECK_ERRCNT_EN
    if (pulses != 1 || o_err_count !== 8'd1 || o_locked !== 1'b1) begin
`else
    if (pulses != 1 || o_err_count !== 8'd0 || o_locked !== 1'b1) begin
`endif
      n_bad++;
      $display("FAIL single_err_summary got pulses=%0d cnt=%0d lk=%b want pulses=1 lk=1", pulses, o_err_count, o_locked);
    end
  endtask

  task automatic test_loss();
    drive(1'b0, 1'b1, 7'b0000000);
    n_vec++;
    if (o_locked !== 1'b1 || o_error !== 1'b1) begin
      n_bad++;
      $display("FAIL loss_first got lk=%b err=%b want lk=1 err=1", o_locked, o_error);
    end
    drive(1'b0, 1'b1, 7'b1100000);
    n_vec++;
    if (o_locked !== 1'b0 || o_error !== 1'b1) begin
      n_bad++;
      $display("FAIL loss_second got lk=%b err=%b want lk=0 err=1", o_locked, o_error);
    end
    drive(1'b0, 1'b1, tbl[1]);
    n_vec++;
    if (o_index_valid !== 1'b1 || o_index !== 3'd1 || o_locked !== 1'b0 || o_error !== 1'b0) begin
      n_bad++;
      $display("FAIL loss_reacquire got v=%b idx=%0d lk=%b err=%b want v=1 idx=1 lk=0 err=0", o_index_valid, o_index, o_locked, o_error);
    end
  endtask

  task automatic test_ambiguous_hunt();
    drive(1'b1, 1'b0, 7'd0);
    for (int k = 0; k < 5; k++) begin
      drive(1'b0, 1'b1, 7'b0100000);
      n_vec++;
      if (o_index_valid !== 1'b0 || o_locked !== 1'b0 || o_error !== 1'b0) begin
        n_bad++;
        $display("FAIL amb_hunt[%0d] got v=%b lk=%b err=%b want 0 0 0", k, o_index_valid, o_locked, o_error);
      end
    end
    drive(1'b0, 1'b1, 7'b0001000);
    n_vec++;
    if (o_index_valid !== 1'b1 || o_index !== 3'd5) begin
      n_bad++;
      $display("FAIL amb_then_unique got v=%b idx=%0d want v=1 idx=5", o_index_valid, o_index);
    end
  endtask

  task automatic test_reset_midlock();
    logic [6:0] seq [9];
    seq = '{tbl[0], tbl[1], tbl[2], tbl[3], 7'd0, tbl[5], 7'd0, tbl[7], 7'd0};
    drive(1'b1, 1'b0, 7'd0);
    foreach (seq[k]) drive(1'b0, 1'b1, seq[k]);
    n_vec++;
`ifdef SEG_CHECK_ERRCNT_EN
    if (o_locked !== 1'b1 || o_err_count !== 8'd3) begin
`else
    if (o_locked !== 1'b1 || o_err_count !== 8'd0) begin
`endif
      n_bad++;
      $display("FAIL midlock_pre got lk=%b cnt=%0d want lk=1", o_locked, o_err_count);
    end
    drive(1'b1, 1'b1, tbl[m_exp]);
    n_vec++;
    if ({o_index, o_index_valid, o_locked, o_error, o_err_count} !== 14'd0) begin
      n_bad++;
      $display("FAIL midlock_reset got %h want 0", {o_index, o_index_valid, o_locked, o_error, o_err_count});
    end
  endtask

  task automatic test_saturation();
    drive(1'b1, 1'b0, 7'd0);
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, tbl[i]);
    for (int k = 0; k < 300; k++) begin
      drive(1'b0, 1'b1, 7'd0);
      drive(1'b0, 1'b1, tbl[m_exp]);
    end
    n_vec++;
`ifdef SEG_CHECK_ERRCNT_EN
    if (o_err_count !== 8'd255 || o_locked !== 1'b1) begin
`else
    if (o_err_count !== 8'd0 || o_locked !== 1'b1) begin
`endif
      n_bad++;
      $display("FAIL saturation got cnt=%0d lk=%b model_cnt=%0d", o_err_count, o_locked, m_cnt);
    end
  endtask

  task automatic test_random();
    int r;
    logic [6:0] s;
    drive(1'b1, 1'b0, 7'd0);
    for (int k = 0; k < 3000; k++) begin
      r = $urandom_range(0, 9);
      if (r < 5) s = tbl[m_exp];
      else if (r < 7) s = tbl[$urandom_range(0, 7)];
      else if (r < 9) s = 7'($urandom);
      else s = 7'd0;
      drive($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0, s);
      n_vec++;
      if ({o_index, o_index_valid, o_locked, o_error, o_err_count} !== {m_index, m_iv, m_locked, m_err, m_cnt}) begin
        n_bad++;
        $display("FAIL random[%0d] got %h want %h", k, {o_index, o_index_valid, o_locked, o_error, o_err_count}, {m_index, m_iv, m_locked, m_err, m_cnt});
      end
    end
  endtask

  initial begin
    test_reset();
    test_lock_sequence();
    test_wrap();
    test_single_error();
    test_loss();
    test_ambiguous_hunt();
    test_reset_midlock();
    test_saturation();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/seg_pattern_checker.md
SEG_PATTERN_CHECKER -- requirements
Module: seg_pattern_checker

Interface
REQ-001 Parameter LOCK_MATCHES, default 4: consecutive in-order matches required in SYNC to enter LOCKED.
REQ-002 Parameter LOSS_MISSES, default 2: consecutive mismatches in LOCKED that force return to HUNT.
REQ-003 i_clk  input  1  single clock; all state updates on the rising edge.
REQ-004 i_rst  input  1  reset, synchronous and active-high.
REQ-005 i_valid  input  1  qualifies i_segment for one cycle.
REQ-006 i_segment  input  7  sampled segment pattern.
REQ-007 o_index  output  3  recovered sequence index.
REQ-008 o_index_valid  output  1  one-cycle pulse marking o_index as updated.
REQ-009 o_locked  output  1  high while the state is LOCKED.
REQ-010 o_error  output  1  one-cycle pulse on each mismatch in LOCKED.
REQ-011 o_err_count  output  8  saturating count of mismatches seen in LOCKED.

Function
REQ-012 Pattern table, index to segment: 0=0000010, 1=1000000, 2=0000001, 3=0010000, 4=0100000, 5=0001000, 6=0000100, 7=0100000.
REQ-013 Pattern 0100000 is ambiguous (index 4 or 7); any pattern not in the table, including 0000000 and multi-bit values, is invalid.
REQ-014 States: HUNT, SYNC, LOCKED. Registers: expected index (3 bits), match counter, miss counter.
REQ-015 When i_valid is low, no state, counter, or expected-index change occurs, and o_index_valid and o_error are 0.
REQ-016 HUNT, valid unique pattern: go to SYNC, expected = decoded+1 mod 8, match counter = 1, o_index = decoded, o_index_valid = 1.
REQ-017 HUNT, ambiguous or invalid pattern: stay in HUNT; no output pulse.
REQ-018 In SYNC and LOCKED, a match is either a unique pattern equal to expected, or the ambiguous pattern when expected is 4 or 7.
REQ-019 SYNC, match: expected advances by 1 (7 wraps to 0), o_index = expected, o_index_valid = 1, match counter increments; at LOCK_MATCHES, go to LOCKED.
REQ-020 SYNC, mismatch: re-acquire as in REQ-016 if the pattern is unique; otherwise go to HUNT. No o_error.
REQ-021 LOCKED, match: expected advances, o_index = expected, o_index_valid = 1, miss counter cleared.
REQ-022 LOCKED, mismatch: o_error = 1, o_err_count increments (saturates at 255), miss counter increments, expected still advances (flywheel), o_index_valid = 0.
REQ-023 LOCKED, miss counter reaching LOSS_MISSES: go to HUNT in the same update. o_err_count is retained.
REQ-024 All outputs are registered; latency from the i_valid sample to the output is 1 cycle.

Reset
REQ-025 While i_rst is high at a clock edge, the state returns to HUNT, expected = 0, and all counters are cleared.
REQ-026 Reset values: o_index=0, o_index_valid=0, o_locked=0, o_error=0, o_err_count=0.
REQ-027 Reset has priority over i_valid, and mid-sequence assertion discards lock.

Configuration
REQ-028 Macro SEG_CHECK_ERRCNT_EN defined: o_err_count is implemented per REQ-022.
REQ-029 Macro not defined: no counter register; o_err_count is tied to 0, and o_error is unaffected.

Structure
REQ-030 Package seg_pattern_pkg holds:
- the 8-entry pattern table constants;
- the ambiguous pattern constant;
- the state enum (HUNT/SYNC/LOCKED).
REQ-031 Sub-module seg_pattern_lookup: combinational 7-bit to {index[2:0], unique, ambiguous} decode, instantiated once.

Verification
REQ-032 Reset, then drive indices 0..7 with the table pattern and i_valid each cycle -> o_locked rises on the 4th sample, and o_index_valid pulses 1 cycle after each sample with o_index = 0..7.
REQ-033 Locked, then continue through 7,0,1 -> o_index shows the wrap 7 to 0, and o_error stays 0.
REQ-034 Locked, expected 3, drive 0000000 once then the correct sequence -> a single o_error pulse, o_err_count = 1, and the block stays locked.
REQ-035 Locked, then two consecutive invalid patterns -> o_locked falls after the 2nd, and a unique pattern re-enters SYNC.
REQ-036 From HUNT, drive 0100000 repeatedly -> the block stays in HUNT with no o_index_valid; then drive 0001000 -> SYNC, o_index = 5.
REQ-037 Assert i_rst while locked with o_err_count = 3 -> all outputs are 0 the next cycle; also force 300 errors with the macro on -> o_err_count = 255.
